// File: rtl/i2c_target_pkg.sv
// ---------------------------------------------------------------------------
// i2c_target_pkg
//   Shared types and constants for the 7-bit I2C target.
//   - state_t       : FSM state encoding (3 bits)
//   - I2C_ACK/NACK  : SDA level during the 9th clock of a byte
//   - BITS_PER_BYTE : data bits per byte on the bus
// ---------------------------------------------------------------------------
package i2c_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_WR_BYTE  = 3'd3,
    ST_WR_ACK   = 3'd4,
    ST_RD_BYTE  = 3'd5,
    ST_RD_ACK   = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  localparam int BITS_PER_BYTE = 8;

  // Bit counter value after the last data bit of a byte has been sampled.
  localparam logic [3:0] BYTE_DONE = 4'(BITS_PER_BYTE);

endpackage

// File: rtl/i2c_bus_sync.sv
// ---------------------------------------------------------------------------
// i2c_bus_sync
//   Oversamples SCL/SDA on clk and derives single-clk event strobes.
//   Ports:
//     clk, rst_n          : system clock, async active-low reset
//     scl, sda            : raw bus lines
//     scl_rise, scl_fall  : one-clk strobes on synchronized SCL edges
//     sda_s               : synchronized SDA, aligned with the strobes
//     start_det, stop_det : SDA fall / rise while SCL is high
// ---------------------------------------------------------------------------
module i2c_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic sda_s,
  output logic start_det,
  output logic stop_det
);

  localparam int N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  // Index 0 is the first flop; index N-1 is the oldest sample.
  logic [N-1:0] scl_q;
  logic [N-1:0] sda_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_q <= '1;
      sda_q <= '1;
    end else begin
      scl_q <= {scl_q[N-2:0], scl};
      sda_q <= {sda_q[N-2:0], sda};
    end
  end

  logic scl_new, scl_old, sda_new, sda_old;

  assign scl_new = scl_q[N-2];
  assign scl_old = scl_q[N-1];
  assign sda_new = sda_q[N-2];
  assign sda_old = sda_q[N-1];

  assign scl_rise  = scl_new & ~scl_old;
  assign scl_fall  = ~scl_new & scl_old;
  assign sda_s     = sda_new;

  // SCL must be high in both stages so an SDA change coinciding with an
  // SCL edge is never mistaken for a bus condition.
  assign start_det = scl_new & scl_old & sda_old & ~sda_new;
  assign stop_det  = scl_new & scl_old & ~sda_old & sda_new;

endmodule

// File: rtl/i2c_target.sv
// ---------------------------------------------------------------------------
// i2c_target
//   7-bit I2C target with a 16-bit write word (RX_DATA) and a 16-bit read
//   word (TX_DATA, captured at address ACK). No clock stretching.
//   Ports:
//     clk       : system clock, >= 8x SCL
//     RESET     : async active-low reset
//     SCL       : bus clock from the generator
//     SDA_IN    : bus data driven by the generator
//     TX_DATA   : word returned on a read
//     SDA_OUT   : target data toward the generator (valid when SDA_OE=1)
//     SDA_OE    : target drives SDA
//     RX_DATA   : last completed write word
//     RX_VALID  : one-clk pulse when RX_DATA updates
//     ADDR_HIT  : own address ACKed, until next START/STOP
//     BUSY      : between START and STOP
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_IDLE     | bus free, waiting for START
//   ST_ADDR     | shifting 7 address bits + RNW
//   ST_ADDR_ACK | driving address ACK, then branch on RNW
//   ST_WR_BYTE  | sampling a write byte
//   ST_WR_ACK   | driving ACK (bytes 0,1) or NACK (later bytes)
//   ST_RD_BYTE  | presenting a read byte, MSB first
//   ST_RD_ACK   | SDA released, sampling controller ACK/NACK
//   ST_IGNORE   | not addressed / finished, wait for START or STOP
// ---------------------------------------------------------------------------
module i2c_target
  import i2c_target_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR    = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        RESET,
  input  logic        SCL,
  input  logic        SDA_IN,
  input  logic [15:0] TX_DATA,
  output logic        SDA_OUT,
  output logic        SDA_OE,
  output logic [15:0] RX_DATA,
  output logic        RX_VALID,
  output logic        ADDR_HIT,
  output logic        BUSY
);

  logic scl_rise, scl_fall, sda_s, start_det, stop_det;

  i2c_bus_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_bus_sync (
    .clk       (clk),
    .rst_n     (RESET),
    .scl       (SCL),
    .sda       (SDA_IN),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .sda_s     (sda_s),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  state_t      state, state_n;
  logic [3:0]  bit_cnt, bit_cnt_n;
  logic [15:0] shreg, shreg_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic        rnw, rnw_n;
  logic        mack, mack_n;
  logic        sda_out_n, sda_oe_n, rx_valid_n, addr_hit_n, busy_n;
  logic [15:0] rx_data_n;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state    <= ST_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      byte_idx <= '0;
      rnw      <= 1'b0;
      mack     <= I2C_NACK;
      SDA_OUT  <= 1'b1;
      SDA_OE   <= 1'b0;
      RX_DATA  <= '0;
      RX_VALID <= 1'b0;
      ADDR_HIT <= 1'b0;
      BUSY     <= 1'b0;
    end else begin
      state    <= state_n;
      bit_cnt  <= bit_cnt_n;
      shreg    <= shreg_n;
      byte_idx <= byte_idx_n;
      rnw      <= rnw_n;
      mack     <= mack_n;
      SDA_OUT  <= sda_out_n;
      SDA_OE   <= sda_oe_n;
      RX_DATA  <= rx_data_n;
      RX_VALID <= rx_valid_n;
      ADDR_HIT <= addr_hit_n;
      BUSY     <= busy_n;
    end
  end

  always_comb begin
    state_n    = state;
    bit_cnt_n  = bit_cnt;
    shreg_n    = shreg;
    byte_idx_n = byte_idx;
    rnw_n      = rnw;
    mack_n     = mack;
    sda_out_n  = SDA_OUT;
    sda_oe_n   = SDA_OE;
    rx_data_n  = RX_DATA;
    rx_valid_n = 1'b0;
    addr_hit_n = ADDR_HIT;
    busy_n     = BUSY;

    if (stop_det) begin
      state_n    = ST_IDLE;
      bit_cnt_n  = '0;
      sda_oe_n   = 1'b0;
      sda_out_n  = 1'b1;
      busy_n     = 1'b0;
      addr_hit_n = 1'b0;
    end else if (start_det) begin
      state_n    = ST_ADDR;
      bit_cnt_n  = '0;
      sda_oe_n   = 1'b0;
      sda_out_n  = 1'b1;
      busy_n     = 1'b1;
      addr_hit_n = 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          sda_oe_n = 1'b0;
        end

        ST_ADDR: begin
          sda_oe_n = 1'b0;
          if (scl_rise) begin
            shreg_n   = {shreg[14:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            // On the 8th rise the address sits in shreg[6:0], RNW on SDA.
            if (bit_cnt == BYTE_DONE - 4'd1) begin
              rnw_n   = sda_s;
              state_n = (shreg[6:0] == DEV_ADDR) ? ST_ADDR_ACK : ST_IGNORE;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_fall) begin
            // SDA_OE doubles as the phase marker: low means the ACK has
            // not been driven yet, high means the ACK clock just ended.
            if (!SDA_OE) begin
              sda_oe_n   = 1'b1;
              sda_out_n  = I2C_ACK;
              addr_hit_n = 1'b1;
              shreg_n    = TX_DATA;
            end else begin
              byte_idx_n = '0;
              bit_cnt_n  = '0;
              if (rnw) begin
                state_n   = ST_RD_BYTE;
                sda_out_n = shreg[15];
              end else begin
                state_n   = ST_WR_BYTE;
                sda_oe_n  = 1'b0;
                sda_out_n = 1'b1;
              end
            end
          end
        end

        ST_WR_BYTE: begin
          if (scl_rise) begin
            shreg_n   = {shreg[14:0], sda_s};
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == BYTE_DONE - 4'd1) begin
              state_n = ST_WR_ACK;
            end
          end
        end

        ST_WR_ACK: begin
          if (scl_fall) begin
            if (!SDA_OE) begin
              if (byte_idx == 2'd2) begin
                // Beyond the 16-bit word: leave SDA released (NACK).
                state_n = ST_IGNORE;
              end else begin
                sda_oe_n  = 1'b1;
                sda_out_n = I2C_ACK;
                if (byte_idx == 2'd1) begin
                  rx_data_n  = shreg;
                  rx_valid_n = 1'b1;
                end
              end
            end else begin
              sda_oe_n   = 1'b0;
              sda_out_n  = 1'b1;
              bit_cnt_n  = '0;
              byte_idx_n = byte_idx + 2'd1;
              state_n    = ST_WR_BYTE;
            end
          end
        end

        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_n = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == BYTE_DONE) begin
              sda_oe_n  = 1'b0;
              sda_out_n = 1'b1;
              state_n   = ST_RD_ACK;
            end else begin
              shreg_n   = {shreg[14:0], 1'b0};
              sda_out_n = shreg[14];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            mack_n = sda_s;
          end else if (scl_fall) begin
            bit_cnt_n = '0;
            if (mack == I2C_ACK && byte_idx == 2'd0) begin
              state_n    = ST_RD_BYTE;
              byte_idx_n = 2'd1;
              sda_oe_n   = 1'b1;
              sda_out_n  = shreg[14];
              shreg_n    = {shreg[14:0], 1'b0};
            end else begin
              state_n = ST_IGNORE;
            end
          end
        end

        ST_IGNORE: begin
          sda_oe_n  = 1'b0;
          sda_out_n = 1'b1;
        end

        default: begin
          state_n  = ST_IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_i2c_target
//   Bit-banged I2C controller driving i2c_target; directed table, repeated
//   START and reset sequences, then random transfers against a transfer-level
//   reference model.
// ---------------------------------------------------------------------------
module tb_i2c_target;

  localparam logic [6:0] DEV = 7'h2A;
  localparam int Q = 4;  // clk cycles per quarter SCL period

  logic        clk     = 1'b0;
  logic        RESET   = 1'b1;
  logic        SCL     = 1'b1;
  logic        SDA_IN  = 1'b1;
  logic [15:0] TX_DATA = 16'h0000;
  logic        SDA_OUT, SDA_OE, RX_VALID, ADDR_HIT, BUSY;
  logic [15:0] RX_DATA;

  int tests = 0;
  int fails = 0;
  int valid_total = 0;
  int oe_total = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (RX_VALID === 1'b1) valid_total <= valid_total + 1;
    if (SDA_OE === 1'b1) oe_total <= oe_total + 1;
  end

  i2c_target #(
    .DEV_ADDR    (DEV),
    .SYNC_STAGES (2)
  ) dut (
    .clk      (clk),
    .RESET    (RESET),
    .SCL      (SCL),
    .SDA_IN   (SDA_IN),
    .TX_DATA  (TX_DATA),
    .SDA_OUT  (SDA_OUT),
    .SDA_OE   (SDA_OE),
    .RX_DATA  (RX_DATA),
    .RX_VALID (RX_VALID),
    .ADDR_HIT (ADDR_HIT),
    .BUSY     (BUSY)
  );

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic gen_start();
    SDA_IN = 1'b1; tick(Q);
    SCL    = 1'b1; tick(Q);
    SDA_IN = 1'b0; tick(Q);
    SCL    = 1'b0; tick(Q);
  endtask

  task automatic gen_stop();
    SDA_IN = 1'b0; tick(Q);
    SCL    = 1'b1; tick(Q);
    SDA_IN = 1'b1; tick(Q);
  endtask

  // One SCL clock; returns the wired-AND bus level and SDA_OE at mid-high.
  task automatic gen_bit(input logic b, output logic line, output logic oe);
    tick(Q);
    SDA_IN = b;
    tick(Q);
    SCL = 1'b1;
    tick(Q);
    oe   = SDA_OE;
    line = SDA_IN & (SDA_OE ? SDA_OUT : 1'b1);
    tick(Q);
    SCL = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, output logic ack_line);
    logic line, oe;
    for (int i = 7; i >= 0; i--) gen_bit(v[i], line, oe);
    gen_bit(1'b1, ack_line, oe);
  endtask

  // START, address, data phase. No STOP; caller decides.
  task automatic xfer(input logic [6:0] addr, input logic rnw, input int n,
                      input logic [23:0] wb, input logic [1:0] mack,
                      input logic [15:0] tx, input logic [15:0] tx_late,
                      output logic aline, output logic [2:0] wacks,
                      output logic [15:0] rd, output logic hit,
                      output logic busy, output int mack_oe);
    logic       line, oe;
    logic [7:0] byte_v;
    wacks   = '0;
    rd      = '0;
    mack_oe = 0;
    TX_DATA = tx;
    gen_start();
    busy = BUSY;
    send_byte({addr, rnw}, aline);
    hit = ADDR_HIT;
    TX_DATA = tx_late;
    for (int b = 0; b < n; b++) begin
      if (!rnw) begin
        byte_v = wb[23 - 8*b -: 8];
        send_byte(byte_v, line);
        wacks[b] = line;
      end else begin
        for (int i = 7; i >= 0; i--) begin
          gen_bit(1'b1, line, oe);
          rd[8*(1-b) + i] = line;
        end
        gen_bit(mack[b], line, oe);
        if (oe) mack_oe++;
      end
    end
  endtask

  // Transfer-level reference: who ACKs, what is read back, what lands in RX.
  function automatic void model(input logic [6:0] addr, input logic rnw, input int n,
                                input logic [23:0] wb, input logic [1:0] mack,
                                input logic [15:0] tx, input logic [15:0] rx_prev,
                                output logic aline, output logic [2:0] wacks,
                                output logic [15:0] rd, output logic [15:0] rx,
                                output int nvalid, output logic hit);
    hit    = (addr == DEV);
    aline  = !hit;
    wacks  = '0;
    rd     = 16'hFFFF;
    rx     = rx_prev;
    nvalid = 0;
    if (!rnw) begin
      for (int b = 0; b < n; b++) wacks[b] = !(hit && b < 2);
      if (hit && n >= 2) begin
        rx     = wb[23:8];
        nvalid = 1;
      end
    end else if (hit) begin
      rd[15:8] = tx[15:8];
      if (mack[0] == 1'b0) rd[7:0] = tx[7:0];
    end
  endfunction

  task automatic run_case(input string tag, input logic [6:0] addr, input logic rnw,
                          input int n, input logic [23:0] wb, input logic [1:0] mack,
                          input logic [15:0] tx, input logic [15:0] tx_late,
                          input logic exp_aline, input logic [2:0] exp_wacks,
                          input logic [15:0] exp_rd, input logic [15:0] exp_rx,
                          input int exp_valid, input logic exp_hit);
    logic        aline, hit, busy;
    logic [2:0]  wacks, wmask;
    logic [15:0] rd, rmask;
    int          mack_oe, v0, o0;
    v0 = valid_total;
    o0 = oe_total;
    wmask = 3'((1 << n) - 1);
    rmask = (n == 1) ? 16'hFF00 : 16'hFFFF;
    xfer(addr, rnw, n, wb, mack, tx, tx_late, aline, wacks, rd, hit, busy, mack_oe);
    check({tag, " addr_ack"}, aline, exp_aline);
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " addr_hit"}, hit, exp_hit);
    if (!rnw) begin
      check({tag, " wr_acks"}, wacks & wmask, exp_wacks & wmask);
    end else begin
      check({tag, " rd_data"}, rd & rmask, exp_rd & rmask);
      check({tag, " oe_in_mack"}, mack_oe, 0);
    end
    tick(Q);
    check({tag, " oe_released"}, SDA_OE, 1'b0);
    gen_stop();
    tick(Q);
    check({tag, " busy_after_stop"}, BUSY, 1'b0);
    check({tag, " hit_after_stop"}, ADDR_HIT, 1'b0);
    check({tag, " rx_data"}, RX_DATA, exp_rx);
    check({tag, " rx_valid_pulses"}, valid_total - v0, exp_valid);
    if (!exp_hit) check({tag, " oe_never"}, oe_total - o0, 0);
  endtask

  typedef struct {
    logic [6:0]  addr;
    logic        rnw;
    int          n;
    logic [23:0] wb;
    logic [1:0]  mack;
    logic [15:0] tx;
    logic [15:0] tx_late;
    logic        exp_aline;
    logic [2:0]  exp_wacks;
    logic [15:0] exp_rd;
    logic [15:0] exp_rx;
    int          exp_valid;
    logic        exp_hit;
  } vec_t;

  function automatic vec_t mk(input logic [6:0] addr, input logic rnw, input int n,
                              input logic [23:0] wb, input logic [1:0] mack,
                              input logic [15:0] tx, input logic [15:0] tx_late,
                              input logic exp_aline, input logic [2:0] exp_wacks,
                              input logic [15:0] exp_rd, input logic [15:0] exp_rx,
                              input int exp_valid, input logic exp_hit);
    vec_t v;
    v.addr = addr; v.rnw = rnw; v.n = n; v.wb = wb; v.mack = mack;
    v.tx = tx; v.tx_late = tx_late; v.exp_aline = exp_aline;
    v.exp_wacks = exp_wacks; v.exp_rd = exp_rd; v.exp_rx = exp_rx;
    v.exp_valid = exp_valid; v.exp_hit = exp_hit;
    return v;
  endfunction

  vec_t vecs[8];

  initial begin
    logic        line, oe, aline, hit, busy;
    logic [2:0]  wacks;
    logic [15:0] rd, ref_rx;
    int          mack_oe, v0;

    // mack bit i = controller response after read byte i (0 = ACK)
    vecs[0] = mk(7'h2A, 1'b0, 2, 24'hBEEF00, 2'b11, 16'h0000, 16'h0000, 1'b0, 3'b000, 16'h0000, 16'hBEEF, 1, 1'b1);
    vecs[1] = mk(7'h2A, 1'b1, 2, 24'h000000, 2'b10, 16'hA55A, 16'h0000, 1'b0, 3'b000, 16'hA55A, 16'hBEEF, 0, 1'b1);
    vecs[2] = mk(7'h15, 1'b0, 2, 24'h123400, 2'b11, 16'h0000, 16'h0000, 1'b1, 3'b011, 16'h0000, 16'hBEEF, 0, 1'b0);
    vecs[3] = mk(7'h2A, 1'b0, 3, 24'h5678AB, 2'b11, 16'h0000, 16'h0000, 1'b0, 3'b100, 16'h0000, 16'h5678, 1, 1'b1);
    vecs[4] = mk(7'h2A, 1'b1, 2, 24'h000000, 2'b11, 16'h1234, 16'hFFFF, 1'b0, 3'b000, 16'h12FF, 16'h5678, 0, 1'b1);
    vecs[5] = mk(7'h2A, 1'b0, 1, 24'h9A0000, 2'b11, 16'h0000, 16'h0000, 1'b0, 3'b000, 16'h0000, 16'h5678, 0, 1'b1);
    vecs[6] = mk(7'h2B, 1'b1, 1, 24'h000000, 2'b01, 16'h5A5A, 16'h5A5A, 1'b1, 3'b000, 16'hFFFF, 16'h5678, 0, 1'b0);
    vecs[7] = mk(7'h6A, 1'b0, 2, 24'h000000, 2'b11, 16'h0000, 16'h0000, 1'b1, 3'b011, 16'h0000, 16'h5678, 0, 1'b0);

    // Power-on reset
    #2 RESET = 1'b0;
    tick(3);
    check("por sda_oe", SDA_OE, 1'b0);
    check("por sda_out", SDA_OUT, 1'b1);
    check("por rx_data", RX_DATA, 16'h0000);
    check("por rx_valid", RX_VALID, 1'b0);
    check("por addr_hit", ADDR_HIT, 1'b0);
    check("por busy", BUSY, 1'b0);
    RESET = 1'b1;
    tick(4);

    // Reset held 3 clk in the middle of a write
    TX_DATA = 16'h0000;
    gen_start();
    send_byte({DEV, 1'b0}, aline);
    check("midbus addr_ack", aline, 1'b0);
    for (int i = 0; i < 3; i++) gen_bit(1'b1, line, oe);
    check("midbus busy_before", BUSY, 1'b1);
    RESET = 1'b0;
    tick(3);
    check("midbus sda_oe", SDA_OE, 1'b0);
    check("midbus rx_data", RX_DATA, 16'h0000);
    check("midbus busy", BUSY, 1'b0);
    check("midbus rx_valid", RX_VALID, 1'b0);
    RESET = 1'b1;
    tick(2);
    gen_stop();
    tick(Q);

    // Directed table
    for (int k = 0; k < 8; k++) begin
      run_case($sformatf("vec%0d", k), vecs[k].addr, vecs[k].rnw, vecs[k].n, vecs[k].wb,
               vecs[k].mack, vecs[k].tx, vecs[k].tx_late, vecs[k].exp_aline,
               vecs[k].exp_wacks, vecs[k].exp_rd, vecs[k].exp_rx,
               vecs[k].exp_valid, vecs[k].exp_hit);
    end

    // Repeated START: one write byte, then read; no RX update
    v0 = valid_total;
    TX_DATA = 16'h1111;
    gen_start();
    send_byte({DEV, 1'b0}, aline);
    check("rs wr addr_ack", aline, 1'b0);
    send_byte(8'h12, line);
    check("rs wr byte_ack", line, 1'b0);
    xfer(DEV, 1'b1, 2, 24'h0, 2'b10, 16'hC3D4, 16'hEEEE, aline, wacks, rd, hit, busy, mack_oe);
    check("rs rd addr_ack", aline, 1'b0);
    check("rs rd addr_hit", hit, 1'b1);
    check("rs rd data", rd, 16'hC3D4);
    check("rs oe_in_mack", mack_oe, 0);
    tick(Q);
    gen_stop();
    tick(Q);
    check("rs rx_valid_pulses", valid_total - v0, 0);
    check("rs rx_data", RX_DATA, 16'h5678);

    // Reset mid-read after 5 bits of byte 0
    TX_DATA = 16'hA55A;
    gen_start();
    send_byte({DEV, 1'b1}, aline);
    check("rstrd addr_ack", aline, 1'b0);
    for (int i = 0; i < 5; i++) gen_bit(1'b1, line, oe);
    check("rstrd oe_before", SDA_OE, 1'b1);
    RESET = 1'b0;
    #1;
    check("rstrd oe_async", SDA_OE, 1'b0);
    check("rstrd busy", BUSY, 1'b0);
    check("rstrd addr_hit", ADDR_HIT, 1'b0);
    check("rstrd rx_cleared", RX_DATA, 16'h0000);
    tick(3);
    RESET = 1'b1;
    tick(1);
    gen_stop();
    tick(Q);
    run_case("after_rst", DEV, 1'b0, 2, 24'h010200, 2'b11, 16'h0, 16'h0,
             1'b0, 3'b000, 16'h0, 16'h0102, 1, 1'b1);

    // Random transfers against the reference model
    ref_rx = 16'h0102;
    for (int t = 0; t < 30; t++) begin
      logic [6:0]  r_addr;
      logic        r_rnw, e_aline, e_hit;
      int          r_n, e_valid;
      logic [23:0] r_wb;
      logic [1:0]  r_mack;
      logic [15:0] r_tx, r_late, e_rd, e_rx;
      logic [2:0]  e_wacks;
      r_addr = ($urandom_range(0, 1) == 1) ? DEV : 7'($urandom_range(0, 127));
      r_rnw  = 1'($urandom_range(0, 1));
      r_n    = r_rnw ? int'($urandom_range(1, 2)) : int'($urandom_range(1, 3));
      r_wb   = 24'($urandom);
      r_mack = 2'($urandom_range(0, 3));
      r_mack[r_n-1] = 1'b1;
      r_tx   = 16'($urandom);
      r_late = 16'($urandom);
      model(r_addr, r_rnw, r_n, r_wb, r_mack, r_tx, ref_rx,
            e_aline, e_wacks, e_rd, e_rx, e_valid, e_hit);
      run_case($sformatf("rnd%0d", t), r_addr, r_rnw, r_n, r_wb, r_mack, r_tx, r_late,
               e_aline, e_wacks, e_rd, e_rx, e_valid, e_hit);
      ref_rx = e_rx;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
